// File: rtl/peri_timer_pkg.sv
//==============================================================================
// Module  : peri_timer_pkg
// Brief   : Shared register offsets, bit indices, reset values and types for
//           the memory-mapped 8-bit peripheral timer.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package peri_timer_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 8;

    // Register offsets within the 8-address window
    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_STAT   = 3'd1;
    localparam logic [2:0] OFF_COUNT  = 3'd2;
    localparam logic [2:0] OFF_PERIOD = 3'd3;
    localparam logic [2:0] OFF_PRESC  = 3'd4;

    // STAT bit indices
    localparam int unsigned STAT_OVF = 0;
    localparam int unsigned STAT_RUN = 1;

    // Reset values
    localparam logic [DATA_W-1:0] COUNT_RST  = 8'h00;
    localparam logic [DATA_W-1:0] PERIOD_RST = 8'hFF;
    localparam logic [DATA_W-1:0] PRESC_RST  = 8'h00;

    // CTRL register: only the low three bits are implemented
    typedef struct packed {
        logic oneshot;
        logic irq_en;
        logic en;
    } ctrl_t;

    localparam ctrl_t CTRL_RST = '{oneshot: 1'b0, irq_en: 1'b0, en: 1'b0};

endpackage

`default_nettype wire

// File: rtl/peri_timer_if.sv
//==============================================================================
// Module  : peri_timer_if
// Brief   : CPU peripheral bus (addr/data/wr_en/rd_en) bundle with a master
//           (CPU) and slave (responder) view.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

interface peri_timer_if;
    import peri_timer_pkg::*;

    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              wr_en;
    logic              rd_en;

    modport master (
        output addr,
        output data_in,
        output wr_en,
        output rd_en,
        input  data_out
    );

    modport slave (
        input  addr,
        input  data_in,
        input  wr_en,
        input  rd_en,
        output data_out
    );

endinterface

`default_nettype wire

// File: rtl/peri_timer_prescaler.sv
//==============================================================================
// Module  : peri_timer_prescaler
// Brief   : Clock prescaler. Counts 0..presc while enabled and pulses tick on
//           the terminal value; held at zero when disabled or cleared.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module peri_timer_prescaler
    import peri_timer_pkg::*;
(
    input  wire logic              clk_ip,
    input  wire logic              reset_n_ip,
    input  wire logic              en,
    input  wire logic              clr,
    input  wire logic [DATA_W-1:0] presc,
    output logic                   tick
);

    logic [DATA_W-1:0] pcnt_q;
    logic [DATA_W-1:0] pcnt_d;

    // Tick fires on the cycle the phase counter sits on the prescale value
    assign tick = en & (pcnt_q == presc);

    // Next phase: clear on disable/software clear, wrap after tick, else advance
    always_comb begin
        pcnt_d = pcnt_q;
        if (!en || clr) begin
            pcnt_d = '0;
        end else if (tick) begin
            pcnt_d = '0;
        end else begin
            pcnt_d = pcnt_q + 8'd1;
        end
    end

    // Phase counter register
    always_ff @(posedge clk_ip or negedge reset_n_ip) begin
        if (!reset_n_ip) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/peri_timer.sv
//==============================================================================
// Module  : peri_timer
// Brief   : Memory-mapped 8-bit timer on the CPU peripheral bus. Register
//           file, counter/period match, overflow flag and level interrupt.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module peri_timer
    import peri_timer_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = 8'h10
) (
    input  wire logic    clk_ip,
    input  wire logic    reset_n_ip,
    peri_timer_if.slave  bus,
    output logic         irq_op
);

    logic              sel;
    logic [2:0]        off;
    logic              wr_sel;
    logic              wr_ctrl;
    logic              wr_stat;
    logic              wr_count;
    logic              wr_period;
    logic              wr_presc;
    logic              tick;
    logic              match;
    logic [DATA_W-1:0] rdata;

    ctrl_t             ctrl_q,   ctrl_d;
    logic              ovf_q,    ovf_d;
    logic [DATA_W-1:0] count_q,  count_d;
    logic [DATA_W-1:0] period_q, period_d;
    logic [DATA_W-1:0] presc_q,  presc_d;
    logic              irq_q,    irq_d;

    assign sel       = (bus.addr[7:3] == BASE_ADDR[7:3]);
    assign off       = bus.addr[2:0];
    assign wr_sel    = bus.wr_en & sel;
    assign wr_ctrl   = wr_sel & (off == OFF_CTRL);
    assign wr_stat   = wr_sel & (off == OFF_STAT);
    assign wr_count  = wr_sel & (off == OFF_COUNT);
    assign wr_period = wr_sel & (off == OFF_PERIOD);
    assign wr_presc  = wr_sel & (off == OFF_PRESC);

    // A software COUNT write on a tick suppresses both the match and increment
    assign match = tick & ~wr_count & (count_q == period_q);

    peri_timer_prescaler u_prescaler (
        .clk_ip     (clk_ip),
        .reset_n_ip (reset_n_ip),
        .en         (ctrl_q.en),
        .clr        (wr_ctrl | wr_presc),
        .presc      (presc_q),
        .tick       (tick)
    );

    // Register file next-state: software writes, counter step, OVF set/clear
    always_comb begin
        ctrl_d   = ctrl_q;
        ovf_d    = ovf_q;
        count_d  = count_q;
        period_d = period_q;
        presc_d  = presc_q;
        irq_d    = ovf_q & ctrl_q.irq_en;

        if (wr_count) begin
            count_d = bus.data_in;
        end else if (tick) begin
            count_d = match ? '0 : count_q + 8'd1;
        end

        // Hardware set beats a same-cycle W1C
        if (match) begin
            ovf_d = 1'b1;
        end else if (wr_stat && bus.data_in[STAT_OVF]) begin
            ovf_d = 1'b0;
        end

        // Written EN beats one-shot auto-disable
        if (wr_ctrl) begin
            ctrl_d = ctrl_t'(bus.data_in[2:0]);
        end else if (match && ctrl_q.oneshot) begin
            ctrl_d.en = 1'b0;
        end

        if (wr_period) begin
            period_d = bus.data_in;
        end
        if (wr_presc) begin
            presc_d = bus.data_in;
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk_ip or negedge reset_n_ip) begin
        if (!reset_n_ip) begin
            ctrl_q   <= CTRL_RST;
            ovf_q    <= 1'b0;
            count_q  <= COUNT_RST;
            period_q <= PERIOD_RST;
            presc_q  <= PRESC_RST;
            irq_q    <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            ovf_q    <= ovf_d;
            count_q  <= count_d;
            period_q <= period_d;
            presc_q  <= presc_d;
            irq_q    <= irq_d;
        end
    end

    // Zero-latency read mux; unimplemented offsets and bits read as zero
    always_comb begin
        rdata = '0;
        case (off)
            OFF_CTRL:   rdata = {5'd0, ctrl_q};
            OFF_STAT:   rdata = {6'd0, ctrl_q.en, ovf_q};
            OFF_COUNT:  rdata = count_q;
            OFF_PERIOD: rdata = period_q;
            OFF_PRESC:  rdata = presc_q;
            default:    rdata = '0;
        endcase
    end

    assign bus.data_out = (bus.rd_en & sel) ? rdata : '0;
    assign irq_op       = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_peri_timer.sv
//==============================================================================
// Module  : tb_peri_timer
// Brief   : Self-checking bench for peri_timer: directed scenarios plus random
//           bus traffic compared against a behavioural timer model.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_peri_timer;

    localparam logic [7:0] BASE = 8'h10;

    logic clk_ip = 1'b0;
    logic reset_n_ip;
    logic irq_op;

    int checks   = 0;
    int failures = 0;

    peri_timer_if bus ();

    peri_timer #(.BASE_ADDR(BASE)) dut (
        .clk_ip     (clk_ip),
        .reset_n_ip (reset_n_ip),
        .bus        (bus),
        .irq_op     (irq_op)
    );

    always #5 clk_ip = ~clk_ip;

    // ---------------- behavioural model ----------------
    logic [2:0] m_ctrl;     // {oneshot, irq_en, en}
    logic       m_ovf;
    logic [7:0] m_count;
    logic [7:0] m_period;
    logic [7:0] m_presc;
    logic [7:0] m_phase;    // clocks elapsed in the current prescale interval
    logic       m_irq;

    task automatic model_reset();
        m_ctrl   = 3'b000;
        m_ovf    = 1'b0;
        m_count  = 8'h00;
        m_period = 8'hFF;
        m_presc  = 8'h00;
        m_phase  = 8'h00;
        m_irq    = 1'b0;
    endtask

    function automatic logic [7:0] model_read(input logic [7:0] a, input logic r);
        logic [7:0] v;
        v = 8'h00;
        if (r && (a[7:3] == BASE[7:3])) begin
            case (a[2:0])
                3'd0: v = {5'd0, m_ctrl};
                3'd1: v = {6'd0, m_ctrl[0], m_ovf};
                3'd2: v = m_count;
                3'd3: v = m_period;
                3'd4: v = m_presc;
                default: v = 8'h00;
            endcase
        end
        return v;
    endfunction

    // Advance the model across one rising edge with the given bus activity
    task automatic model_step(input logic [7:0] a, input logic [7:0] d, input logic w);
        logic       we;
        logic       tick;
        logic       expired;
        logic [2:0] o;
        logic [2:0] n_ctrl;
        logic       n_ovf;
        logic [7:0] n_count;
        logic [7:0] n_phase;
        o       = a[2:0];
        we      = w && (a[7:3] == BASE[7:3]);
        tick    = m_ctrl[0] && (m_phase == m_presc);
        expired = tick && !(we && o == 3'd2) && (m_count == m_period);

        n_phase = (tick || !m_ctrl[0]) ? 8'h00 : m_phase + 8'd1;
        if (we && (o == 3'd0 || o == 3'd4)) n_phase = 8'h00;

        n_count = m_count;
        if (we && o == 3'd2)  n_count = d;
        else if (expired)     n_count = 8'h00;
        else if (tick)        n_count = m_count + 8'd1;

        n_ovf = m_ovf;
        if (expired)                        n_ovf = 1'b1;
        else if (we && o == 3'd1 && d[0])   n_ovf = 1'b0;

        n_ctrl = m_ctrl;
        if (we && o == 3'd0)            n_ctrl = d[2:0];
        else if (expired && m_ctrl[2])  n_ctrl[0] = 1'b0;

        m_irq   = m_ovf && m_ctrl[1];
        m_ctrl  = n_ctrl;
        m_ovf   = n_ovf;
        m_count = n_count;
        m_phase = n_phase;
        if (we && o == 3'd3) m_period = d;
        if (we && o == 3'd4) m_presc  = d;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // One bus cycle: drive at negedge, compare outputs against the model,
    // then let the model follow the rising edge.
    task automatic cyc(input logic [7:0] a, input logic [7:0] d, input logic w,
                       input logic r, output logic [7:0] rd_v, output logic irq_v);
        @(negedge clk_ip);
        bus.addr    = a;
        bus.data_in = d;
        bus.wr_en   = w;
        bus.rd_en   = r;
        #1;
        rd_v  = bus.data_out;
        irq_v = irq_op;
        chk("data_out", rd_v, model_read(a, r));
        chk("irq_op", {7'd0, irq_v}, {7'd0, m_irq});
        @(posedge clk_ip);
        model_step(a, d, w);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        logic [7:0] v;
        logic       q;
        cyc(a, d, 1'b1, 1'b0, v, q);
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] v, output logic q);
        cyc(a, 8'h00, 1'b0, 1'b1, v, q);
    endtask

    // Asynchronous reset pulse away from the clock edge
    task automatic do_reset(input string tag);
        @(negedge clk_ip);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        #2 reset_n_ip = 1'b0;
        #1 chk(tag, {7'd0, irq_op}, 8'h00);
        model_reset();
        @(negedge clk_ip);
        reset_n_ip = 1'b1;
    endtask

    logic [7:0] v;
    logic       q;

    initial begin
        reset_n_ip  = 1'b0;
        bus.addr    = 8'h00;
        bus.data_in = 8'h00;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_ip);
        reset_n_ip = 1'b1;

        // Reset values
        rd(BASE + 8'd0, v, q); chk("rst_ctrl",   v, 8'h00);
        rd(BASE + 8'd1, v, q); chk("rst_stat",   v, 8'h00);
        rd(BASE + 8'd2, v, q); chk("rst_count",  v, 8'h00);
        rd(BASE + 8'd3, v, q); chk("rst_period", v, 8'hFF);
        rd(BASE + 8'd4, v, q); chk("rst_presc",  v, 8'h00);
        chk("rst_irq", {7'd0, q}, 8'h00);

        // Periodic: COUNT 0,1,2,3,0 then OVF, irq one cycle later
        wr(BASE + 8'd4, 8'h00);
        wr(BASE + 8'd3, 8'h03);
        wr(BASE + 8'd0, 8'h03);
        for (int i = 0; i < 5; i++) begin
            rd(BASE + 8'd2, v, q);
            chk("per_count", v, 8'(i % 4));
        end
        chk("per_irq_lag", {7'd0, q}, 8'h00);
        rd(BASE + 8'd1, v, q);
        chk("per_stat", v, 8'h03);
        chk("per_irq", {7'd0, q}, 8'h01);

        // Reset mid-run drops irq immediately and restores defaults
        do_reset("async_irq");
        rd(BASE + 8'd3, v, q); chk("rst2_period", v, 8'hFF);
        rd(BASE + 8'd1, v, q); chk("rst2_stat",   v, 8'h00);

        // Prescale: PRESC=2, PERIOD=1 -> COUNT steps every 3 clocks
        wr(BASE + 8'd4, 8'h02);
        wr(BASE + 8'd3, 8'h01);
        wr(BASE + 8'd0, 8'h01);
        for (int i = 0; i < 6; i++) begin
            rd(BASE + 8'd2, v, q);
            chk("psc_count", v, (i < 3) ? 8'h00 : 8'h01);
        end
        rd(BASE + 8'd1, v, q);
        chk("psc_stat", v, 8'h03);
        chk("psc_irq", {7'd0, q}, 8'h00);

        // One-shot expiry clears EN, COUNT parks at zero
        wr(BASE + 8'd0, 8'h00);
        wr(BASE + 8'd1, 8'h01);
        wr(BASE + 8'd2, 8'h00);
        wr(BASE + 8'd4, 8'h00);
        wr(BASE + 8'd3, 8'h02);
        wr(BASE + 8'd0, 8'h05);
        repeat (5) rd(BASE + 8'd2, v, q);
        rd(BASE + 8'd1, v, q); chk("os_stat",  v, 8'h01);
        rd(BASE + 8'd0, v, q); chk("os_ctrl",  v, 8'h04);
        rd(BASE + 8'd2, v, q); chk("os_count", v, 8'h00);

        // Collisions: W1C on match cycle, COUNT write on tick cycle
        wr(BASE + 8'd1, 8'h01);
        wr(BASE + 8'd0, 8'h01);
        rd(BASE + 8'd2, v, q);
        rd(BASE + 8'd2, v, q);
        wr(BASE + 8'd1, 8'h01);
        rd(BASE + 8'd1, v, q); chk("col_w1c", v, 8'h03);
        wr(BASE + 8'd2, 8'h07);
        rd(BASE + 8'd2, v, q); chk("col_count", v, 8'h07);

        // Decode: holes, out-of-window, rd_en low, stray writes
        rd(BASE + 8'd5, v, q); chk("dec_off5", v, 8'h00);
        rd(BASE + 8'd6, v, q); chk("dec_off6", v, 8'h00);
        rd(BASE + 8'd7, v, q); chk("dec_off7", v, 8'h00);
        rd(BASE + 8'd8, v, q); chk("dec_out",  v, 8'h00);
        cyc(BASE + 8'd3, 8'h00, 1'b0, 1'b0, v, q); chk("dec_nord", v, 8'h00);
        wr(BASE + 8'd11, 8'h55);
        wr(8'h03, 8'hAA);
        rd(BASE + 8'd3, v, q); chk("dec_stray", v, 8'h02);
        // Simultaneous read and write returns the pre-write value
        cyc(BASE + 8'd3, 8'h09, 1'b1, 1'b1, v, q); chk("rw_old", v, 8'h02);
        rd(BASE + 8'd3, v, q); chk("rw_new", v, 8'h09);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] a;
            logic [7:0] d;
            logic       w;
            logic       r;
            a = BASE + 8'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) a = 8'($urandom);
            d = 8'($urandom);
            case (a[2:0])
                3'd0:       d[0] = ($urandom_range(0, 3) != 0);
                3'd2:       d = 8'($urandom_range(0, 9));
                3'd3, 3'd4: d = 8'($urandom_range(0, 5));
                default:    d = d;
            endcase
            w = ($urandom_range(0, 7) == 0);
            r = 1'($urandom_range(0, 1));
            cyc(a, d, w, r, v, q);
            if (i == 1500) do_reset("rand_rst");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
